// File: rtl/bus_arbiter_if.sv
// Bus arbiter interface: bundles the request, lock and write-data signals
// from the requesters with the grant and shared-bus outputs of the arbiter.
interface bus_arbiter_if #(
  parameter int DW = 18
);
  logic [3:0]    req;
  logic [3:0]    lock;
  logic [DW-1:0] din0;
  logic [DW-1:0] din1;
  logic [DW-1:0] din2;
  logic [DW-1:0] din3;
  logic [3:0]    gnt;
  logic [DW-1:0] bus;
  logic          bus_valid;
  logic          busy;

  // Requester side: drives requests and data, observes the grant.
  modport master (
    output req, lock, din0, din1, din2, din3,
    input  gnt, bus, bus_valid, busy
  );

  // Arbiter side: samples requests and data, drives the grant and bus.
  modport slave (
    input  req, lock, din0, din1, din2, din3,
    output gnt, bus, bus_valid, busy
  );
endinterface

// File: rtl/bus_arbiter.sv
// Four-requester round-robin bus arbiter with locked (held) grants.
// A grant lasts one cycle unless the winner asserts lock, in which case it
// is held for up to MAX_LOCK consecutive cycles. All outputs are registered.
module bus_arbiter #(
  parameter int DW       = 18,
  parameter int MAX_LOCK = 15
) (
  input  logic        clk,
  input  logic        rst,
  bus_arbiter_if.slave bif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    LOCK  = 2'd2
  } state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [DW-1:0] bus_q, bus_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;

  logic [DW-1:0] din [4];
  logic          win_found;
  logic [1:0]    win;
  logic          hold_ok;

  assign din[0] = bif.din0;
  assign din[1] = bif.din1;
  assign din[2] = bif.din2;
  assign din[3] = bif.din3;

  // Round-robin search from ptr+1 upward; the previous owner (ptr) is
  // visited last, which gives it lowest priority on every re-arbitration.
  always_comb begin
    logic [1:0] idx;
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned -- that is what keeps latches from being inferred.
    win_found = 1'b0;
    win       = ptr_q;
    idx       = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + k[1:0];
      if (!win_found && bif.req[idx]) begin
        win_found = 1'b1;
        win       = idx;
      end
    end
  end

  // A locked owner keeps the bus only while it still requests with lock
  // and has not used up its hold budget; anything from non-owners is ignored.
  assign hold_ok = (state_q == LOCK) && bif.req[ptr_q] && bif.lock[ptr_q]
                   && (cnt_q < MAX_CNT);

  // Next-state and next-output logic: hold, re-arbitrate, or go idle.
  always_comb begin
    state_d = IDLE;
    ptr_d   = ptr_q;
    cnt_d   = 8'd0;
    gnt_d   = 4'b0000;
    bus_d   = '0;
    valid_d = 1'b0;
    if (hold_ok) begin
      state_d = LOCK;
      cnt_d   = cnt_q + 8'd1;
      gnt_d   = gnt_q;
      bus_d   = din[ptr_q];
      valid_d = 1'b1;
    end else if (win_found) begin
      ptr_d   = win;
      gnt_d   = 4'b0001 << win;
      bus_d   = din[win];
      valid_d = 1'b1;
      if (bif.lock[win]) begin
        state_d = LOCK;
        cnt_d   = 8'd1;
      end else begin
        state_d = GRANT;
      end
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset wins over every other event.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, matching the hardware.
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      cnt_q   <= 8'd0;
      gnt_q   <= 4'b0000;
      bus_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      bus_q   <= bus_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bif.gnt       = gnt_q;
  assign bif.bus       = bus_q;
  assign bif.bus_valid = valid_q;
  assign bif.busy      = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: a directed vector table, hand-written
// lock/reset sequences, and randomized traffic compared against a
// transaction-level model of owner, hold count and round-robin pointer.
module tb_bus_arbiter;
  localparam int DW = 18;
  localparam int ML = 15;

  logic clk = 1'b0;
  logic rst;

  bus_arbiter_if #(.DW(DW)) bif ();

  bus_arbiter #(.DW(DW), .MAX_LOCK(ML)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] din_v [4];

  // Reference model state: who owns the bus, whether the grant is locked,
  // how many cycles it has been held, and the last winner index.
  int            m_owner  = -1;
  bit            m_locked = 1'b0;
  int            m_hold   = 0;
  int            m_ptr    = 3;
  logic [3:0]    e_gnt    = 4'b0000;
  logic [DW-1:0] e_bus    = '0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] gnt;
    int         src;
    logic       busy;
  } vec_t;

  vec_t tbl [11];

  task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] lk);
    rst       = r;
    bif.req   = rq;
    bif.lock  = lk;
    bif.din0  = din_v[0];
    bif.din1  = din_v[1];
    bif.din2  = din_v[2];
    bif.din3  = din_v[3];
  endtask

  task automatic model_step();
    int w;
    if (rst) begin
      m_ptr = 3; m_owner = -1; m_locked = 1'b0; m_hold = 0;
      e_gnt = 4'b0000; e_bus = '0;
      return;
    end
    if (m_locked && bif.req[m_owner] && bif.lock[m_owner] && m_hold < ML) begin
      m_hold++;
      e_bus = din_v[m_owner];
      return;
    end
    w = -1;
    for (int k = 1; k <= 4; k++)
      if (w < 0 && bif.req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
    if (w < 0) begin
      m_owner = -1; m_locked = 1'b0; m_hold = 0;
      e_gnt = 4'b0000; e_bus = '0;
    end else begin
      m_owner  = w;
      m_ptr    = w;
      m_locked = bif.lock[w];
      m_hold   = m_locked ? 1 : 0;
      e_gnt    = 4'(1 << w);
      e_bus    = din_v[w];
    end
  endtask

  // One clock: model advances on the same edge as the DUT, outputs are
  // then inspected at the following falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [3:0] eg,
                       input logic [DW-1:0] eb, input logic ebusy);
    n_vec++;
    if (bif.gnt !== eg || bif.bus !== eb || bif.bus_valid !== (|eg) || bif.busy !== ebusy) begin
      n_err++;
      $display("FAIL %s @%0t: got gnt=%b bus=%h valid=%b busy=%b, want gnt=%b bus=%h valid=%b busy=%b",
               name, $time, bif.gnt, bif.bus, bif.bus_valid, bif.busy, eg, eb, |eg, ebusy);
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 4'b0000, 4'b0000);
    tick();
    check("reset", 4'b0000, '0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0]    rq, lk;
    logic          r;
    logic [DW-1:0] eb;
    int            wait_c [4];
    int            run;
    logic [3:0]    prev_gnt;

    din_v[0] = 18'h00A01;
    din_v[1] = 18'h00B02;
    din_v[2] = 18'h2A5A5;
    din_v[3] = 18'h3C3C3;

    // rst, req, lock, expected gnt, expected bus source (-1 = zero), busy
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, -1, 1'b0};
    tbl[1]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, -1, 1'b0};
    tbl[2]  = '{1'b0, 4'b1111, 4'b0000, 4'b0001,  0, 1'b1};
    tbl[3]  = '{1'b0, 4'b1111, 4'b0000, 4'b0010,  1, 1'b1};
    tbl[4]  = '{1'b0, 4'b1111, 4'b0000, 4'b0100,  2, 1'b1};
    tbl[5]  = '{1'b0, 4'b1111, 4'b0000, 4'b1000,  3, 1'b1};
    tbl[6]  = '{1'b0, 4'b1111, 4'b0000, 4'b0001,  0, 1'b1};
    tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, -1, 1'b0};
    tbl[8]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100,  2, 1'b1};
    tbl[9]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, -1, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, -1, 1'b0};

    drive(1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].lock);
      tick();
      eb = (tbl[i].src < 0) ? '0 : din_v[tbl[i].src];
      check($sformatf("table[%0d]", i), tbl[i].gnt, eb, tbl[i].busy);
    end

    // Locked owner 1 with requester 3 waiting: held exactly MAX_LOCK cycles,
    // with the bus reloaded from din1 every cycle.
    do_reset();
    for (int k = 0; k < ML; k++) begin
      din_v[1] = DW'($urandom);
      drive(1'b0, 4'b1010, 4'b0010);
      tick();
      check($sformatf("lock_hold[%0d]", k), 4'b0010, din_v[1], 1'b1);
    end
    tick();
    check("lock_timeout", 4'b1000, din_v[3], 1'b1);

    // Locked owner 0 drops lock after 3 cycles: requester 2 follows with no gap.
    do_reset();
    drive(1'b0, 4'b0101, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("lock_drop_hold[%0d]", k), 4'b0001, din_v[0], 1'b1);
    end
    drive(1'b0, 4'b0101, 4'b0000);
    tick();
    check("lock_drop_next", 4'b0100, din_v[2], 1'b1);

    // Reset on the fourth cycle of a lock, then a fresh request.
    do_reset();
    drive(1'b0, 4'b0001, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("pre_rst_lock[%0d]", k), 4'b0001, din_v[0], 1'b1);
    end
    drive(1'b1, 4'b0001, 4'b0001);
    tick();
    check("rst_mid_lock", 4'b0000, '0, 1'b0);
    drive(1'b0, 4'b0001, 4'b0000);
    tick();
    check("post_rst_grant", 4'b0001, din_v[0], 1'b1);

    // Randomized traffic: request/lock patterns persist for several cycles
    // so locked holds and contention actually occur.
    rq = 4'b0000; lk = 4'b0000; run = 1; prev_gnt = 4'b0000;
    for (int i = 0; i < 4; i++) wait_c[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(7) == 0) begin
        rq = 4'($urandom);
        lk = 4'($urandom);
      end
      r = ($urandom_range(999) == 0);
      for (int i = 0; i < 4; i++) din_v[i] = DW'($urandom);
      drive(r, rq, lk);
      tick();
      check("rand_model", e_gnt, e_bus, e_gnt != 4'b0000);

      n_vec++;
      if (!$onehot0(bif.gnt) || bif.bus_valid !== (|bif.gnt)) begin
        n_err++;
        $display("FAIL rand_onehot cycle %0d: gnt=%b bus_valid=%b, want one-hot/zero gnt and valid=|gnt",
                 c, bif.gnt, bif.bus_valid);
      end

      if (!r && bif.gnt != 4'b0000 && bif.gnt == prev_gnt && (rq & ~bif.gnt) != 4'b0000) run++;
      else run = 1;
      prev_gnt = bif.gnt;
      n_vec++;
      if (run > ML) begin
        n_err++;
        $display("FAIL rand_hold cycle %0d: owner gnt=%b held %0d cycles under contention, limit %0d",
                 c, bif.gnt, run, ML);
      end

      n_vec++;
      for (int i = 0; i < 4; i++) begin
        if (!r && rq[i] && !bif.gnt[i]) wait_c[i]++;
        else wait_c[i] = 0;
      end
      if (wait_c[0] > 3*ML+3 || wait_c[1] > 3*ML+3 || wait_c[2] > 3*ML+3 || wait_c[3] > 3*ML+3) begin
        n_err++;
        $display("FAIL rand_starve cycle %0d: waits=%0d,%0d,%0d,%0d, limit %0d",
                 c, wait_c[0], wait_c[1], wait_c[2], wait_c[3], 3*ML+3);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
